// File: rtl/ec_decryption.sv
// ec_decryption: sequential EC-ElGamal decryptor, M = C2 - d*C1.
//
// Curve: y^2 = x^3 + 5 over GF(7). Its group has prime order 7, so the complete
// homogeneous-projective addition law used below covers every case: doubling,
// P + (-P) and the identity (0,1,0). No input needs special handling.
//
// d*C1 is computed MSB-first with double-and-add over a single shared
// point-addition datapath. The sum is computed on every ADD step and only
// committed when the key bit is 1, so latency does not depend on the key.
// A final step adds C2 to the negated accumulator.
//
// Optional macro DEC_VARTIME_EN: skip leading zero key bits. The accumulator
// is preloaded with C1 at accept, which gives a key-dependent latency and
// identical results.
//
// Ports:
//   clk, reset                : clock; synchronous active-high reset
//   in_valid / in_ready       : ciphertext and key handshake (ready only in idle)
//   x_C1..z_C1, x_C2..z_C2    : ciphertext points C1, C2 (projective)
//   priv_key                  : private scalar d
//   out_valid / out_ready     : plaintext handshake (valid held until taken)
//   x/y/z_Plaintext           : recovered point M (projective)
//   Decryption_complete       : one-cycle pulse when out_valid rises
module ec_decryption #(
  parameter int unsigned N     = 3,
  parameter int unsigned KEY_W = 3,
  parameter int unsigned P     = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x_C1,
  input  logic [N-1:0]     y_C1,
  input  logic [N-1:0]     z_C1,
  input  logic [N-1:0]     x_C2,
  input  logic [N-1:0]     y_C2,
  input  logic [N-1:0]     z_C2,
  input  logic [KEY_W-1:0] priv_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     x_Plaintext,
  output logic [N-1:0]     y_Plaintext,
  output logic [N-1:0]     z_Plaintext,
  output logic             Decryption_complete
);

  localparam int unsigned IdxW   = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int unsigned WW     = 2 * N;
  localparam int unsigned CurveB = 5;
  localparam logic [WW-1:0] PW   = WW'(P);
  localparam logic [N-1:0]  B3N  = N'((3 * CurveB) % P);

  typedef struct packed {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] z;
  } point_t;

  typedef enum logic [2:0] {StIdle, StDbl, StAdd, StSub, StOut} state_e;

  localparam point_t Identity = '{x: '0, y: N'(1), z: '0};

  // Field helpers: operands are zero-extended to 2N bits and reduced mod P.
  function automatic logic [N-1:0] f_red(input logic [WW-1:0] a);
    return N'(a % PW);
  endfunction

  function automatic logic [N-1:0] f_add(input logic [N-1:0] a, input logic [N-1:0] b);
    return f_red({{N{1'b0}}, a} + {{N{1'b0}}, b});
  endfunction

  function automatic logic [N-1:0] f_sub(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [WW-1:0] bb;
    bb = {{N{1'b0}}, b} % PW;
    return f_red({{N{1'b0}}, a} + PW - bb);
  endfunction

  function automatic logic [N-1:0] f_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    return f_red({{N{1'b0}}, a} * {{N{1'b0}}, b});
  endfunction

  // Complete addition for a = 0 short Weierstrass curves, with b3 = 3b.
  function automatic point_t f_padd(input point_t p1, input point_t p2);
    logic [N-1:0] t0, t1, t2, xy, yz, xz, t0x3, s, d;
    point_t r;
    t0   = f_mul(p1.x, p2.x);
    t1   = f_mul(p1.y, p2.y);
    t2   = f_mul(B3N, f_mul(p1.z, p2.z));
    xy   = f_add(f_mul(p1.x, p2.y), f_mul(p2.x, p1.y));
    yz   = f_add(f_mul(p1.y, p2.z), f_mul(p2.y, p1.z));
    xz   = f_add(f_mul(p1.x, p2.z), f_mul(p2.x, p1.z));
    t0x3 = f_add(f_add(t0, t0), t0);
    s    = f_add(t1, t2);
    d    = f_sub(t1, t2);
    r.x  = f_sub(f_mul(xy, d), f_mul(B3N, f_mul(yz, xz)));
    r.y  = f_add(f_mul(s, d), f_mul(f_mul(B3N, xz), t0x3));
    r.z  = f_add(f_mul(yz, s), f_mul(t0x3, xy));
    return r;
  endfunction

  state_e           r_state, w_state_d;
  point_t           r_c1, w_c1_d;
  point_t           r_c2, w_c2_d;
  point_t           r_acc, w_acc_d;
  point_t           r_m, w_m_d;
  logic [KEY_W-1:0] r_key, w_key_d;
  logic [IdxW-1:0]  r_idx, w_idx_d;
  logic             r_out_valid, w_out_valid_d;
  logic             r_done, w_done_d;

  point_t w_pa_a, w_pa_b, w_pa_s, w_neg_acc;

  // Shared adder operand select.
  always_comb begin
    w_neg_acc   = r_acc;
    w_neg_acc.y = f_sub(N'(0), r_acc.y);
    w_pa_a      = r_acc;
    w_pa_b      = r_acc;
    unique case (r_state)
      StAdd: w_pa_b = r_c1;
      StSub: begin
        w_pa_a = r_c2;
        w_pa_b = w_neg_acc;
      end
      default: ;
    endcase
    w_pa_s = f_padd(w_pa_a, w_pa_b);
  end

`ifdef DEC_VARTIME_EN
  logic [IdxW-1:0] w_msb;
  logic            w_key_any;

  always_comb begin
    w_msb     = '0;
    w_key_any = 1'b0;
    for (int i = 0; i < int'(KEY_W); i++) begin
      if (priv_key[i]) begin
        w_msb     = IdxW'(i);
        w_key_any = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    w_state_d     = r_state;
    w_c1_d        = r_c1;
    w_c2_d        = r_c2;
    w_acc_d       = r_acc;
    w_m_d         = r_m;
    w_key_d       = r_key;
    w_idx_d       = r_idx;
    w_out_valid_d = r_out_valid;
    w_done_d      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_c1_d  = '{x: x_C1, y: y_C1, z: z_C1};
          w_c2_d  = '{x: x_C2, y: y_C2, z: z_C2};
          w_key_d = priv_key;
`ifdef DEC_VARTIME_EN
          // The top set bit is consumed by preloading C1.
          if (!w_key_any) begin
            w_acc_d   = Identity;
            w_state_d = StSub;
          end else begin
            w_acc_d = '{x: x_C1, y: y_C1, z: z_C1};
            if (w_msb == '0) begin
              w_state_d = StSub;
            end else begin
              w_idx_d   = w_msb - IdxW'(1);
              w_state_d = StDbl;
            end
          end
`else
          w_acc_d   = Identity;
          w_idx_d   = IdxW'(KEY_W - 1);
          w_state_d = StDbl;
`endif
        end
      end
      StDbl: begin
        w_acc_d   = w_pa_s;
        w_state_d = StAdd;
      end
      StAdd: begin
        if (r_key[r_idx]) begin
          w_acc_d = w_pa_s;
        end
        if (r_idx == '0) begin
          w_state_d = StSub;
        end else begin
          w_idx_d   = r_idx - IdxW'(1);
          w_state_d = StDbl;
        end
      end
      StSub: begin
        w_m_d         = w_pa_s;
        w_out_valid_d = 1'b1;
        w_done_d      = 1'b1;
        w_state_d     = StOut;
      end
      StOut: begin
        if (out_ready) begin
          w_out_valid_d = 1'b0;
          w_state_d     = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_c1        <= '0;
      r_c2        <= '0;
      r_acc       <= Identity;
      r_m         <= '0;
      r_key       <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_c1        <= w_c1_d;
      r_c2        <= w_c2_d;
      r_acc       <= w_acc_d;
      r_m         <= w_m_d;
      r_key       <= w_key_d;
      r_idx       <= w_idx_d;
      r_out_valid <= w_out_valid_d;
      r_done      <= w_done_d;
    end
  end

  assign in_ready            = (r_state == StIdle);
  assign out_valid           = r_out_valid;
  assign Decryption_complete = r_done;
  assign x_Plaintext         = r_m.x;
  assign y_Plaintext         = r_m.y;
  assign z_Plaintext         = r_m.z;

endmodule

// File: doc/ec_decryption.md
Name: ec_decryption

Overview:
- Sequential EC-ElGamal decryptor; the receive side of the encryption path.
- Takes ciphertext (C1, C2) in projective coordinates and private key d; computes M = C2 − d·C1.
- Scalar multiply is an iterative, constant-time MSB-first double-and-add over one shared `pointAddition` instance, followed by a negate-and-add.
- Sits after the encryption block in the coordinate-system datapath; valid/ready on both sides.

Parameters:
- N, 3, coordinate width in bits.
- KEY_W, 3, private-key width; number of double-and-add iterations.
- P, 7, field prime for negation; must be < 2^N and match the modulus hardwired in `pointAddition`.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- in_valid  in  1  ciphertext/key presented.
- in_ready  out  1  block can accept; high only in IDLE.
- x_C1, y_C1, z_C1  in  N each  ciphertext point C1.
- x_C2, y_C2, z_C2  in  N each  ciphertext point C2.
- priv_key  in  KEY_W  private scalar d.
- out_valid  out  1  plaintext valid; held until taken.
- out_ready  in  1  downstream accepts plaintext.
- x_Plaintext, y_Plaintext, z_Plaintext  out  N each  recovered point M.
- Decryption_complete  out  1  one-cycle pulse on the edge out_valid first rises.

Behaviour:
- Reset values:
  - state = IDLE; in_ready = 1 (combinational from state).
  - out_valid = 0; Decryption_complete = 0.
  - Plaintext outputs = 0; accumulator = identity (0,1,0).
- Reset mid-operation aborts: the in-flight job and any pending output are discarded.
- Accept occurs at edge k when in_valid && in_ready. On that edge:
  - latch C1, C2, priv_key;
  - acc ← (0,1,0); idx ← KEY_W−1; state ← DBL.
- DBL: acc ← pointAddition(acc, acc); go to ADD.
- ADD:
  - Always compute pointAddition(acc, C1). Commit the sum only if key[idx] = 1, otherwise hold acc (constant time).
  - If idx == 0, go to SUB; else idx ← idx−1 and go to DBL.
- SUB:
  - Form negS = (acc.X, (P − acc.Y) mod P, acc.Z); note Y = 0 maps to 0.
  - Register M ← pointAddition(C2, negS); out_valid ← 1; Decryption_complete ← 1 for this edge only; state ← OUT.
- OUT:
  - Outputs stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid ← 0; state ← IDLE. in_ready is high the next cycle.
- Latency: out_valid rises at edge k + 2·KEY_W + 1 (7 cycles at default), independent of key value.
- Only one job in flight. No new accept while busy or OUT, even if out_ready is high in the same cycle as the handoff.
- d = 0: acc stays identity; M = C2 + identity (projectively equal to C2).
- Z = 0 anywhere is the identity class; no error signalled. Results are compared projectively: equal after scaling by a nonzero Z.
- All arithmetic is mod P inside `pointAddition`; width N throughout with no widening. Upper key bits are ignored above KEY_W.
- Inputs are sampled only at the accept edge; changes afterwards are ignored.

Optional Feature:
- Macro: DEC_VARTIME_EN.
- Defined (leading-zero skip):
  - At accept, idx is loaded with the position of the MSB set in priv_key and acc is preloaded with C1; the first DBL/ADD pair is skipped.
  - d = 0 goes straight to SUB with acc = identity.
  - Latency = 2·msb(d) + 1 cycles for d ≠ 0; 1 cycle for d = 0.
  - Results are identical to the constant-time mode.
- Undefined: constant latency 2·KEY_W + 1; timing does not depend on the key.

Test Plan:
- Reset, then idle: in_ready = 1, out_valid = 0, outputs 0, Decryption_complete = 0.
- priv_key=0, C2=(3,2,1), C1 arbitrary, accept at edge k:
  - out_valid rises at k+7;
  - M is projectively equal to (3,2,1);
  - Decryption_complete high for exactly 1 cycle.
- priv_key=1, C1=C2=Q (a valid curve point):
  - M.Z = 0 (identity);
  - repeating with priv_key=2, C2=2·Q (from bench model) also gives Z = 0.
- Round trip:
  - Encrypt known M with key d=4, r=3 using the bench model; feed (C1, C2) with priv_key=4;
  - M is recovered projectively; sweep all priv_key 0..7.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid; outputs must stay stable and in_ready stay 0.
  - Raise out_ready; in_ready = 1 on the next cycle.
- Assert reset 3 cycles after accept:
  - state returns to IDLE next edge; out_valid never rises.
  - A new job after reset completes with the correct result.
